io_hex_display_ctrl: RTL

//  Sequencer between the CPU's memory-mapped output ports and the six HEX displays.

---
 rtl/io_hex_display_ctrl_pkg.sv | 32 +++
 rtl/io_hex_display_ctrl_if.sv | 27 ++
 rtl/io_hex_display_ctrl_seg7_decoder.sv | 12 +
 rtl/io_hex_display_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/io_hex_display_ctrl_pkg.sv
// Shared types for the HEX display sequencer: FSM states, special segment patterns
// and the 0-9 active-low seven-segment table.
package io_hex_display_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_STORE = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Segment order {g,f,e,d,c,b,a}; a cleared bit lights the segment.
  function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/io_hex_display_ctrl_if.sv
// Port bundle between the CPU output-port block and the HEX display sequencer.
// No handshake: channel values are level inputs, hex outputs are registered levels.
interface io_hex_display_ctrl_if;

  logic [31:0] chan0_in;
  logic [31:0] chan1_in;
  logic [31:0] chan2_in;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;
  logic        busy;
  logic        frame_done;

  modport master (
    output chan0_in, chan1_in, chan2_in,
    input  hex0, hex1, hex2, hex3, hex4, hex5, busy, frame_done
  );

  modport slave (
    input  chan0_in, chan1_in, chan2_in,
    output hex0, hex1, hex2, hex3, hex4, hex5, busy, frame_done
  );

endinterface

// File: rtl/io_hex_display_ctrl_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; purely combinational, zero latency.
// Codes 10-15 never reach the displays and map to blank.
module seg7_decoder
  import io_hex_display_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg_lookup(digit);

endmodule

// File: rtl/io_hex_display_ctrl.sv
// Round-robins three channels through one double-dabble engine; a pair updates BIN_W+2
// cycles after its LOAD, no backpressure. HEX_LEAD_BLANK_EN blanks a leading zero tens digit.
module io_hex_display_ctrl
  import io_hex_display_ctrl_pkg::*;
#(
  parameter int MAX_VAL     = 99,
  parameter int BIN_W       = 7,
  parameter int IDLE_CYCLES = 0
) (
  input logic                  clock,
  input logic                  resetn,
  io_hex_display_ctrl_if.slave bus
);

  localparam int SCR_W = BIN_W + 8;
  localparam int CNT_W = $clog2(IDLE_CYCLES + BIN_W + 1);

  if (2 ** BIN_W <= MAX_VAL) begin : g_bin_w_check
    $error("BIN_W cannot represent MAX_VAL");
  end

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCR_W-1:0] scr_q, scr_d, scr_adj;
  logic             ovf_q, ovf_d;
  logic             store_en, frame_set, frame_done_q;
  logic [31:0]      chan_sel;
  logic [6:0]       hex_q [6];
  logic [3:0]       tens_dig, units_dig;
  logic [6:0]       tens_seg, units_seg, tens_out, units_out;

  always_comb begin
    case (ch_q)
      2'd0:    chan_sel = bus.chan0_in;
      2'd1:    chan_sel = bus.chan1_in;
      default: chan_sel = bus.chan2_in;
    endcase
  end

  // Double-dabble add-3 correction, applied before every left shift.
  always_comb begin
    scr_adj = scr_q;
    if (scr_q[BIN_W+3 -: 4] >= 4'd5) scr_adj[BIN_W+3 -: 4] = scr_q[BIN_W+3 -: 4] + 4'd3;
    if (scr_q[BIN_W+7 -: 4] >= 4'd5) scr_adj[BIN_W+7 -: 4] = scr_q[BIN_W+7 -: 4] + 4'd3;
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    scr_d     = scr_q;
    ovf_d     = ovf_q;
    store_en  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q == CNT_W'(IDLE_CYCLES)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        ovf_d   = (chan_sel > 32'(MAX_VAL));
        scr_d   = {8'b0, chan_sel[BIN_W-1:0]};
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        scr_d = scr_adj << 1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = S_STORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STORE: begin
        store_en = 1'b1;
        if (ch_q == 2'd2) begin
          ch_d      = 2'd0;
          state_d   = S_IDLE;
          frame_set = 1'b1;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ch_q         <= 2'd0;
      cnt_q        <= '0;
      scr_q        <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      scr_q        <= scr_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_set;
    end
  end

  assign units_dig = scr_q[BIN_W+3 -: 4];
  assign tens_dig  = scr_q[BIN_W+7 -: 4];

  seg7_decoder u_tens  (.digit(tens_dig),  .seg(tens_seg));
  seg7_decoder u_units (.digit(units_dig), .seg(units_seg));

  always_comb begin
    units_out = ovf_q ? SEG_DASH : units_seg;
    tens_out  = tens_seg;
`ifdef HEX_LEAD_BLANK_EN
    if (tens_dig == 4'd0) tens_out = SEG_BLANK;
`endif
    if (ovf_q) tens_out = SEG_DASH;
  end

  // Only STORE touches the display registers, so an aborted conversion leaves no trace.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else if (store_en) begin
      case (ch_q)
        2'd0: begin
          hex_q[0] <= units_out;
          hex_q[1] <= tens_out;
        end
        2'd1: begin
          hex_q[2] <= units_out;
          hex_q[3] <= tens_out;
        end
        default: begin
          hex_q[4] <= units_out;
          hex_q[5] <= tens_out;
        end
      endcase
    end
  end

  assign bus.hex0       = hex_q[0];
  assign bus.hex1       = hex_q[1];
  assign bus.hex2       = hex_q[2];
  assign bus.hex3       = hex_q[3];
  assign bus.hex4       = hex_q[4];
  assign bus.hex5       = hex_q[5];
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done_q;

endmodule
